div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have clock/reset: one clock; reset is synchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  synchronous active-low reset, sampled on clk.
REQ-004 SHALL have port: start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port: signed_div  input  1  1 = two's-complement (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 SHALL have port: annul  input  1  abort the in-flight division (flush).
REQ-007 SHALL have port: opdata1  input  32  dividend; sampled with start.
REQ-008 SHALL have port: opdata2  input  32  divisor; sampled with start.
REQ-009 SHALL have port: result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 SHALL have port: ready  output  1  result valid; feeds the execute-stage divider-control ready input.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, BYZERO, ON, END.
REQ-012 In IDLE with start=1 and annul=0, SHALL latch operands and mode; go to BYZERO if opdata2==0, else go to ON with iteration counter=0.
REQ-013 In IDLE with start=0 or annul=1, SHALL stay in IDLE with ready=0 and result=0.
REQ-014 In signed mode, SHALL latch the absolute values of both operands and record sign(dividend) and sign(dividend) XOR sign(divisor).
REQ-015 In ON, SHALL perform one radix-2 restoring step per cycle on a 65-bit partial-remainder/quotient register.
REQ-016 SHALL run exactly 32 ON cycles (counter 0..31), then go to END.
REQ-017 Latency: start sampled at edge T -> state END and ready=1 during cycle T+33 (non-zero divisor).
REQ-018 Latency: start sampled at edge T with divisor zero -> BYZERO during T+1, END during T+2.
REQ-019 In signed mode, SHALL negate the quotient when the operand signs differ.
REQ-020 In signed mode, SHALL give the remainder the sign of the dividend.
REQ-021 SHALL wrap -2^31 / -1 (signed) to quotient 0x80000000, remainder 0, with no trap.
REQ-022 On divide by zero, SHALL make result 64'h0.
REQ-023 result and ready SHALL be registered and change only on clk edges.
REQ-024 SHALL assert ready only in END and hold result stable there.
REQ-025 In END with start=1, SHALL stay in END; with start=0, SHALL go to IDLE, clearing ready and result next cycle.
REQ-026 annul=1 in BYZERO or ON SHALL force IDLE on the next edge, with ready=0 and no result produced.
REQ-027 annul SHALL have priority over start, over iteration and over the END transition.
REQ-028 SHALL ignore operand/mode input changes while not in IDLE.

Reset
REQ-029 rst=0 at any edge SHALL force: state IDLE, counter 0, ready 0, result 64'h0, internal operand registers 0.
REQ-030 Reset mid-division SHALL discard the operation; the first start after rst=1 SHALL begin cleanly.

Structure
REQ-031 FSM state encodings and the DIV_CYCLES=32 constant SHALL live in shared defines.vh alongside the DIV/DIVU control codes.
REQ-032 SHALL be a single module, no sub-modules; the abs/negate logic SHALL be inline combinational.

Verification
REQ-033 Bench SHALL cover: unsigned 100/7 -> ready at T+33, result={32'd2, 32'd14}.
REQ-034 Bench SHALL cover: signed -7/2 -> result={32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-035 Bench SHALL cover: unsigned 0xFFFFFFFF/0x10 -> {32'hF, 32'h0FFFFFFF}.
REQ-036 Bench SHALL cover: signed 0x80000000/0xFFFFFFFF -> {32'h0, 32'h80000000}.
REQ-037 Bench SHALL cover: opdata2=0 -> ready at T+2, result=64'h0.
REQ-038 Bench SHALL cover annul at iteration 10, then a fresh 9/3: no ready pulse before restart; restart yields {0, 3}.
REQ-039 Bench SHALL cover rst=0 at iteration 5: next cycle ready=0, result=0, IDLE.
REQ-040 Bench SHALL cover start held high in END: ready stays 1 until start drops, then 0 on the next edge.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared FSM encoding, iteration count and control codes for the divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_BYZERO = 2'b01,
    S_ON     = 2'b10,
    S_END    = 2'b11
  } div_state_t;

  localparam int DIV_CYCLES = 32;

  // Function codes of the instructions the execute stage routes to this unit.
  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam logic [5:0] OP_DIVU = 6'b011011;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, 32-bit signed/unsigned, 32 iterations.
// Result is {remainder, quotient}; ready marks a valid result.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready
);

  div_state_t  state;
  logic [4:0]  cnt;
  logic [64:0] acc;
  logic [31:0] divisor;
  logic        neg_quot;
  logic        neg_rem;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        ge;
  logic [31:0] sub;
  logic [64:0] acc_step;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // acc[64:33] holds the partial remainder; acc[64:32] is that remainder
  // shifted left with the next dividend bit brought in, compared at 33 bits.
  always_comb begin
    abs_a    = (signed_div && opdata1[31]) ? (32'd0 - opdata1) : opdata1;
    abs_b    = (signed_div && opdata2[31]) ? (32'd0 - opdata2) : opdata2;
    ge       = (acc[64:32] >= {1'b0, divisor});
    sub      = acc[63:32] - divisor;
    acc_step = ge ? {sub, acc[31:0], 1'b1} : {acc[63:0], 1'b0};
    quot_fix = neg_quot ? (32'd0 - acc_step[31:0])  : acc_step[31:0];
    rem_fix  = neg_rem  ? (32'd0 - acc_step[64:33]) : acc_step[64:33];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      ready    <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready  <= 1'b0;
          result <= '0;
          if (start && !annul) begin
            divisor  <= abs_b;
            acc      <= {32'd0, abs_a, 1'b0};
            neg_quot <= signed_div & (opdata1[31] ^ opdata2[31]);
            neg_rem  <= signed_div & opdata1[31];
            cnt      <= '0;
            state    <= (opdata2 == 32'd0) ? S_BYZERO : S_ON;
          end
        end

        S_BYZERO: begin
          if (annul) begin
            state  <= S_IDLE;
            ready  <= 1'b0;
            result <= '0;
          end else begin
            state  <= S_END;
            ready  <= 1'b1;
            result <= '0;
          end
        end

        S_ON: begin
          if (annul) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ready  <= 1'b0;
            result <= '0;
          end else if (cnt == 5'(DIV_CYCLES - 1)) begin
            // Final step: sign-correct straight from the last step's value.
            acc    <= acc_step;
            cnt    <= '0;
            state  <= S_END;
            ready  <= 1'b1;
            result <= {rem_fix, quot_fix};
          end else begin
            acc <= acc_step;
            cnt <= cnt + 5'd1;
          end
        end

        S_END: begin
          if (annul || !start) begin
            state  <= S_IDLE;
            ready  <= 1'b0;
            result <= '0;
          end
        end

        default: begin
          state  <= S_IDLE;
          ready  <= 1'b0;
          result <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division; signed truncates toward zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'h0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one division from IDLE, measure edges-to-ready, check result and clear.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn);
    logic [63:0] exp;
    int lat;
    int exp_lat;
    exp     = ref_div(a, b, sgn);
    exp_lat = (b == 32'd0) ? 1 : 32;
    lat     = -1;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    opdata1 = $urandom;
    opdata2 = $urandom;
    signed_div = ~sgn;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    check_int({tag, "_lat"}, lat, exp_lat);
    check64({tag, "_res"}, result, exp);
    $display("div %s a=%h b=%h signed=%0d result=%h expected=%h lat=%0d",
             tag, a, b, sgn, result, exp, lat);
    @(posedge clk);
    #1;
    check64({tag, "_clr"}, {result[63:1], result[0] | ready}, 64'h0);
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] ra, rb;
    int lat;

    rst = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = 32'h1234_5678; opdata2 = 32'h9abc_def0;
    repeat (3) @(posedge clk);
    #1;
    check64("reset_result", result, 64'h0);
    check_int("reset_ready", int'(ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_div("u100_7", 32'd100, 32'd7, 1'b0);
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_div("u_big_16", 32'hFFFF_FFFF, 32'h10, 1'b0);
    do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div("div_zero", 32'd55, 32'd0, 1'b0);
    do_div("u_big_div", 32'hF000_0001, 32'h8000_0003, 1'b0);

    // Annul at iteration 10, then a fresh 9/3.
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (ready) lat++;
    end
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (ready) lat++;
    end
    check_int("annul_no_ready", lat, 0);
    check64("annul_result", result, 64'h0);
    $display("annul at iteration 10 ready_pulses=%0d result=%h", lat, result);
    do_div("after_annul_9_3", 32'd9, 32'd3, 1'b0);

    // Reset at iteration 5.
    opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_int("midrst_ready", int'(ready), 0);
    check64("midrst_result", result, 64'h0);
    $display("reset at iteration 5 ready=%0d result=%h", ready, result);
    do_div("after_rst", 32'hFFFF_FF9C, 32'd7, 1'b1);

    // Start held high through END.
    opdata1 = 32'd50; opdata2 = 32'd6; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    check_int("hold_lat", lat, 32);
    check64("hold_res", result, {32'd2, 32'd8});
    held = result;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (ready && result === held) lat++;
    end
    check_int("hold_stable", lat, 4);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_int("hold_drop_ready", int'(ready), 0);
    check64("hold_drop_result", result, 64'h0);
    $display("start held in END stable_cycles=%0d then ready=%0d", lat, ready);

    // Random operands in both modes, with small, large and zero divisors.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 20);
        3:       rb = 32'd0 - 32'($urandom_range(1, 20));
        4:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      do_div($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
